// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit_if                                           |
// | Description : CPU request/response and data-memory port bundle of the LSU. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : RV32I memory-access stage, one req/ack transaction in flight.|
// |               Optional WAIT timeout enabled by macro LSU_TIMEOUT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
    logic [1:0]  r_resp_err, w_resp_err_nxt;
    logic [2:0]  r_f3, w_f3_nxt;
    logic [1:0]  r_lo, w_lo_nxt;
    logic        r_we, w_we_nxt;

    logic        w_f3_legal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load_ext;
    logic        w_timeout;

    always_comb begin
        w_f3_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = ~bus.req_we;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << bus.req_addr[1:0];
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = bus.req_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign w_shift = bus.mem_rdata >> {r_lo, 3'b000};

    always_comb begin
        w_load_ext = w_shift;
        case (r_f3)
            3'b000:  w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_ext = {24'h000000, w_shift[7:0]};
            3'b101:  w_load_ext = {16'h0000, w_shift[15:0]};
            default: w_load_ext = w_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;

    // Counter is zero everywhere but WAIT, so it is clear on every entry.
    assign w_cnt_nxt = (r_state == S_WAIT) ? (r_cnt + 1'b1) : '0;
    assign w_timeout = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= w_cnt_nxt;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_be_nxt     = r_mem_be;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = 32'h0;
        w_resp_err_nxt   = 2'b00;
        w_f3_nxt         = r_f3;
        w_lo_nxt         = r_lo;
        w_we_nxt         = r_we;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!w_f3_legal || w_misaligned) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = !w_f3_legal ? 2'b10 : 2'b01;
                        w_state_nxt      = S_RESP;
                    end else begin
                        w_f3_nxt        = bus.req_funct3;
                        w_lo_nxt        = bus.req_addr[1:0];
                        w_we_nxt        = bus.req_we;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = bus.req_we;
                        w_mem_addr_nxt  = {bus.req_addr[31:2], 2'b00};
                        w_mem_be_nxt    = w_be;
                        w_mem_wdata_nxt = w_wdata;
                        w_state_nxt     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_ack || w_timeout) begin
                    w_mem_req_nxt    = 1'b0;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_be_nxt     = 4'b0000;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = bus.mem_ack ? 2'b00 : 2'b11;
                    w_resp_rdata_nxt = (bus.mem_ack && !r_we) ? w_load_ext : 32'h0;
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 2'b00;
            r_f3         <= 3'b000;
            r_lo         <= 2'b00;
            r_we         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_be     <= w_mem_be_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_f3         <= w_f3_nxt;
            r_lo         <= w_lo_nxt;
            r_we         <= w_we_nxt;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                           |
// | Description : Directed bench for load_store_unit with a transaction model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;
    localparam int TO = 4;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    // Transaction-level expectations, in cycle indices.
    int          exp_mem_from = -10;
    int          exp_mem_to = -10;
    int          exp_busy_from = -10;
    int          exp_resp_cyc = -10;
    logic [31:0] exp_rdata = 32'h0;
    logic [1:0]  exp_err = 2'b00;
    logic        cur_we = 1'b0;
    logic [2:0]  cur_f3 = 3'b000;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] cur_wdata = 32'h0;

    logic [31:0] last_rdata, last_wdata;
    logic [3:0]  last_be;
    logic [1:0]  last_err;
    logic        last_we;
    logic        in_mem, busy, at_resp;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2'b10;
        if ((int'(addr[1:0]) % m_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << m_size(f3)) - 1) << int'(addr[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (m_size(f3))
            1:       return {24'h0, w[7:0]} * 32'h01010101;
            2:       return {16'h0, w[15:0]} * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(addr[1:0]));
        if (m_size(f3) == 1) begin
            v = v & 32'h000000FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (m_size(f3) == 2) begin
            v = v & 32'h0000FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            in_mem  = (cyc >= exp_mem_from) && (cyc <= exp_mem_to);
            busy    = (cyc >= exp_busy_from) && (cyc <= exp_resp_cyc);
            at_resp = (cyc == exp_resp_cyc);
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("mem_req", 32'(bus.mem_req), 32'(in_mem));
            if (in_mem) begin
                chk("mem_we", 32'(bus.mem_we), 32'(cur_we));
                chk("mem_addr", bus.mem_addr, cur_addr & 32'hFFFFFFFC);
                chk("mem_be", 32'(bus.mem_be), 32'(m_be(cur_f3, cur_addr)));
                if (cur_we) chk("mem_wdata", bus.mem_wdata, m_wdata(cur_f3, cur_wdata));
                last_we    = bus.mem_we;
                last_be    = bus.mem_be;
                last_wdata = bus.mem_wdata;
            end
            chk("resp_valid", 32'(bus.resp_valid), 32'(at_resp));
            if (at_resp) begin
                chk("resp_rdata", bus.resp_rdata, exp_rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
            end else begin
                chk("idle_rdata", bus.resp_rdata, 32'h0);
                chk("idle_err", 32'(bus.resp_err), 32'h0);
            end
        end
    end

    // Present a request for one cycle; returns one cycle after acceptance.
    task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic [1:0] e;
        n = cyc;
        e = m_err(we, f3, addr);
        cur_we = we; cur_f3 = f3; cur_addr = addr; cur_wdata = wd;
        last_rdata = 32'hx; last_err = 2'bx; last_be = 4'bx; last_wdata = 32'hx; last_we = 1'bx;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        exp_busy_from = n + 1;
        if (e != 2'b00) begin
            exp_mem_from = -10; exp_mem_to = -10;
            exp_resp_cyc = n + 1; exp_err = e; exp_rdata = 32'h0;
        end else begin
            exp_mem_from = n + 1; exp_mem_to = NEVER; exp_resp_cyc = NEVER;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_ack(input int delay, input logic [31:0] rd);
        int m;
        repeat (delay) begin @(posedge clk); #1; end
        m = cyc;
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        exp_mem_to = m; exp_resp_cyc = m + 1; exp_err = 2'b00;
        exp_rdata = cur_we ? 32'h0 : m_rdata(cur_f3, cur_addr, rd);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay, input logic [31:0] rd);
        start_req(we, f3, addr, wd);
        if (m_err(we, f3, addr) != 2'b00) begin
            @(posedge clk); #1;
        end else begin
            finish_ack(delay, rd);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        chk("pin_be_b103", 32'(m_be(3'b000, 32'h103)), 32'h8);
        chk("pin_rd_lb", m_rdata(3'b000, 32'h103, 32'h80112233), 32'hFFFFFF80);
        chk("pin_rd_lhu", m_rdata(3'b101, 32'h102, 32'h80017F00), 32'h00008001);
        chk("pin_wd_sh", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
        chk("pin_err_f3", 32'(m_err(1'b0, 3'b011, 32'h0)), 32'h2);

        xact(1'b0, 3'b010, 32'h00000100, 32'h0, 1, 32'hDEADBEEF);
        chk("lw_be", 32'(last_be), 32'hF);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(last_err), 32'h0);

        xact(1'b0, 3'b000, 32'h00000103, 32'h0, 1, 32'h80112233);
        chk("lb_be", 32'(last_be), 32'h8);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 32'h00000103, 32'h0, 2, 32'h80112233);
        chk("lbu_rdata", last_rdata, 32'h00000080);

        xact(1'b1, 3'b001, 32'h00000202, 32'h1234ABCD, 1, 32'hFFFFFFFF);
        chk("sh_we", 32'(last_we), 32'h1);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_rdata", last_rdata, 32'h0);

        xact(1'b0, 3'b010, 32'h00000101, 32'h0, 0, 32'h0);
        chk("lw_mis_err", 32'(last_err), 32'h1);
        xact(1'b0, 3'b011, 32'h00000100, 32'h0, 0, 32'h0);
        chk("ld_f3_err", 32'(last_err), 32'h2);

        xact(1'b0, 3'b001, 32'h00000102, 32'h0, 3, 32'h80017F00);
        chk("lh_rdata", last_rdata, 32'hFFFF8001);
        xact(1'b0, 3'b101, 32'h00000102, 32'h0, 1, 32'h80017F00);
        chk("lhu_rdata", last_rdata, 32'h00008001);
        xact(1'b1, 3'b000, 32'h00000001, 32'h000000A5, 1, 32'h0);
        chk("sb_be", 32'(last_be), 32'h2);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        xact(1'b1, 3'b010, 32'h00000004, 32'hCAFEF00D, 0, 32'h0);
        chk("sw_wdata", last_wdata, 32'hCAFEF00D);
        xact(1'b1, 3'b001, 32'h00000003, 32'h0, 0, 32'h0);
        chk("sh_mis_err", 32'(last_err), 32'h1);
        xact(1'b1, 3'b100, 32'h00000000, 32'h0, 0, 32'h0);
        chk("st_f3_err", 32'(last_err), 32'h2);
        xact(1'b1, 3'b110, 32'h00000003, 32'h0, 0, 32'h0);
        chk("f3_before_align", 32'(last_err), 32'h2);

        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        start_req(1'b0, 3'b010, 32'h00000300, 32'h0);
`ifdef LSU_TIMEOUT_EN
        exp_mem_to = cyc + TO - 1; exp_resp_cyc = cyc + TO;
        exp_err = 2'b11; exp_rdata = 32'h0;
        repeat (TO + 2) begin @(posedge clk); #1; end
        chk("timeout_err", 32'(last_err), 32'h3);
`else
        repeat (300) begin @(posedge clk); #1; end
        chk("withheld_mem_req", 32'(bus.mem_req), 32'h1);
        chk("withheld_ready", 32'(bus.req_ready), 32'h0);
        finish_ack(0, 32'h0BADF00D);
        chk("withheld_rdata", last_rdata, 32'h0BADF00D);
`endif

        start_req(1'b0, 3'b010, 32'h00000400, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        cmp_en = 1'b0;
        exp_mem_from = -10; exp_mem_to = -10; exp_busy_from = -10; exp_resp_cyc = -10;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("arst_ready", 32'(bus.req_ready), 32'h1);
        chk("arst_resp_valid", 32'(bus.resp_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
        chk("post_rst_no_resp", 32'(bus.resp_valid), 32'h0);

        xact(1'b0, 3'b010, 32'h00000500, 32'h0, 1, 32'h12345678);
        chk("post_rst_lw", last_rdata, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
